// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: owns the PC, runs a one-outstanding req/gnt/rvalid fetch and buffers words in a small queue.
// Optional IF_FETCH_NOP_EN: invalid IF/ID slots present addi x0,x0,0 at pc 0 so decode may ignore valid.
module if_fetch_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic [WIDTH-1:0] redirect_pc_in,
    output logic             imem_req_out,
    output logic [WIDTH-1:0] imem_addr_out,
    input  logic             imem_gnt_in,
    input  logic             imem_rvalid_in,
    input  logic [WIDTH-1:0] imem_rdata_in,
    output logic             ifid_valid_out,
    output logic [WIDTH-1:0] ifid_pc_out,
    output logic [WIDTH-1:0] ifid_instr_out
);
    localparam int unsigned      PTR_W      = $clog2(DEPTH);
    localparam int unsigned      CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] NOP_INSTR  = WIDTH'(32'h0000_0013);
`ifdef IF_FETCH_NOP_EN
    localparam logic [WIDTH-1:0] IFID_RST_INSTR = NOP_INSTR;
`else
    localparam logic [WIDTH-1:0] IFID_RST_INSTR = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] issued_pc_q, issued_pc_d;
    logic [WIDTH-1:0] q_pc_q [DEPTH];
    logic [WIDTH-1:0] q_pc_d [DEPTH];
    logic [WIDTH-1:0] q_instr_q [DEPTH];
    logic [WIDTH-1:0] q_instr_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic             req;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] count_after_pop;

    always_comb begin
        pop             = !flush_in && !stall_in && (count_q != '0);
        push            = (state_q == S_WAIT) && imem_rvalid_in && !flush_in;
        count_after_pop = count_q - CNT_W'(pop);
    end

    // Fetch FSM; a flush always wins and either re-requests or drains the in-flight response.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        req         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_in || (count_after_pop < FULL_CNT)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req = 1'b1;
                if (imem_gnt_in) begin
                    pc_d        = pc_q + WIDTH'(4);
                    issued_pc_d = pc_q;
                    state_d     = flush_in ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_in) begin
                    state_d = imem_rvalid_in ? S_REQ : S_DROP;
                end else if (imem_rvalid_in) begin
                    state_d = ((count_after_pop + CNT_W'(1)) < FULL_CNT) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_rvalid_in) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_in) begin
            pc_d = redirect_pc_in & ALIGN_MASK;
        end
    end

    always_comb begin
        q_pc_d    = q_pc_q;
        q_instr_d = q_instr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                q_pc_d[wr_ptr_q]    = issued_pc_q;
                q_instr_d[wr_ptr_q] = imem_rdata_in;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (flush_in || (!stall_in && (count_q == '0))) begin
            ifid_valid_d = 1'b0;
`ifdef IF_FETCH_NOP_EN
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
`endif
        end else if (!stall_in) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = q_pc_q[rd_ptr_q];
            ifid_instr_d = q_instr_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC & ALIGN_MASK;
            issued_pc_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= IFID_RST_INSTR;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issued_pc_q  <= issued_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            q_pc_q       <= q_pc_d;
            q_instr_q    <= q_instr_d;
        end
    end

    assign imem_req_out   = req;
    assign imem_addr_out  = pc_q;
    assign ifid_valid_out = ifid_valid_q;
    assign ifid_pc_out    = ifid_pc_q;
    assign ifid_instr_out = ifid_instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: imem responder returns pc^A5A5_0000, monitor checks every IF/ID load in order.
module tb_if_fetch_stage;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in = 1'b0;
    logic [31:0] imem_rdata_in  = '0;
    logic        ifid_valid_out;
    logic [31:0] ifid_pc_out;
    logic [31:0] ifid_instr_out;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          errors    = 0;
    int          checks    = 0;
    int          matched   = 0;
    int          rv_lat    = 1;
    int          rv_cnt    = 0;
    logic [31:0] rv_addr   = '0;
    logic        load_seen = 1'b0;
`ifdef IF_FETCH_NOP_EN
    localparam logic [31:0] RST_INSTR = 32'h0000_0013;
`else
    localparam logic [31:0] RST_INSTR = 32'h0000_0000;
`endif

    if_fetch_stage #(.WIDTH(32), .DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .redirect_pc_in (redirect_pc_in),
        .imem_req_out   (imem_req_out),
        .imem_addr_out  (imem_addr_out),
        .imem_gnt_in    (imem_gnt_in),
        .imem_rvalid_in (imem_rvalid_in),
        .imem_rdata_in  (imem_rdata_in),
        .ifid_valid_out (ifid_valid_out),
        .ifid_pc_out    (ifid_pc_out),
        .ifid_instr_out (ifid_instr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] p;
        exp_t        e;
        p = start;
        for (int i = 0; i < n; i++) begin
            e.pc    = p;
            e.instr = p ^ 32'hA5A5_0000;
            exp_q.push_back(e);
            p = p + 32'd4;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Returns at the falling edge of the next granted request, with its address.
    task automatic wait_grant(input string name, output logic [31:0] addr);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!(imem_req_out && imem_gnt_in) && n < 60);
        addr = imem_addr_out;
        if (!(imem_req_out && imem_gnt_in)) begin
            checks++;
            errors++;
            $display("FAIL %s: no granted request within %0d cycles", name, n);
        end
    endtask

    // Instruction memory: one outstanding request, response rv_lat cycles after the grant.
    always begin
        @(negedge clk_in);
        if (rst_n_in && imem_req_out && imem_gnt_in) begin
            rv_addr = imem_addr_out;
            rv_cnt  = rv_lat;
        end
        @(posedge clk_in);
        #1;
        imem_rvalid_in = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                imem_rvalid_in = 1'b1;
                imem_rdata_in  = rv_addr ^ 32'hA5A5_0000;
            end
        end
    end

    always @(posedge clk_in) load_seen <= rst_n_in && !stall_in && !flush_in;

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (load_seen && ifid_valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h instr %h with no expected entry", ifid_pc_out, ifid_instr_out);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", ifid_pc_out, e.pc);
                check("sb_instr", ifid_instr_out, e.instr);
                matched++;
            end
        end
`ifdef IF_FETCH_NOP_EN
        if (rst_n_in && !ifid_valid_out) begin
            check("nop_instr", ifid_instr_out, 32'h0000_0013);
            check("nop_pc", ifid_pc_out, 32'h0000_0000);
        end
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] frozen_pc;
        int          n;
        int          seen;

        rst_n_in       = 1'b0;
        stall_in       = 1'b0;
        flush_in       = 1'b0;
        redirect_pc_in = '0;
        imem_gnt_in    = 1'b1;
        cycles(2);
        check("rst_req", imem_req_out, 0);
        check("rst_addr", imem_addr_out, 32'h0);
        check("rst_valid", ifid_valid_out, 0);
        check("rst_pc", ifid_pc_out, 32'h0);
        check("rst_instr", ifid_instr_out, RST_INSTR);
        expect_seq(32'h0, 40);
        rst_n_in = 1'b1;

        // First request and its latency to IF/ID.
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!imem_req_out && n < 20);
        check("first_req_seen", imem_req_out, 1);
        check("first_req_addr", imem_addr_out, 32'h0);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!ifid_valid_out && n < 20);
        check("first_valid_latency", n, 3);
        wait_grant("addr_seq_8", addr);
        check("addr_seq_8", addr, 32'h8);
        wait_grant("addr_seq_c", addr);
        check("addr_seq_c", addr, 32'hC);
        cycles(10);

        // Stall 6 cycles starting in a WAIT cycle with the queue empty.
        wait_grant("stall_align", addr);
        @(posedge clk_in);
        #1;
        stall_in  = 1'b1;
        seen      = 0;
        frozen_pc = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            if (i == 0) frozen_pc = ifid_pc_out;
            if (imem_rvalid_in) seen++;
            if (i >= 3) check("stall_full_req", imem_req_out, 0);
            if (i == 5) begin
                check("stall_frozen_pc", ifid_pc_out, frozen_pc);
                check("stall_frozen_valid", ifid_valid_out, 1);
            end
            @(posedge clk_in);
            #1;
        end
        stall_in = 1'b0;
        check("stall_accepted", seen, 2);
        cycles(16);

        // Flush while waiting on a slow response: it must be drained, then fetch at 0x100.
        rv_lat = 3;
        wait_grant("flush_wait_grant", addr);
        @(posedge clk_in);
        #1;
        flush_in       = 1'b1;
        redirect_pc_in = 32'h0000_0103;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        exp_q.delete();
        expect_seq(32'h0000_0100, 40);
        seen = 0;
        n    = 0;
        do begin
            @(negedge clk_in);
            n++;
            if (imem_rvalid_in) seen++;
        end while (!imem_req_out && n < 20);
        check("drop_rvalid_count", seen, 1);
        check("redirect_addr", imem_addr_out, 32'h0000_0100);
        @(posedge clk_in);
        #1;
        rv_lat = 1;
        cycles(12);

        // Fill the queue under stall, then flush with stall still asserted.
        stall_in = 1'b1;
        cycles(10);
        @(negedge clk_in);
        check("park_req", imem_req_out, 0);
        @(posedge clk_in);
        #1;
        flush_in       = 1'b1;
        redirect_pc_in = 32'h0000_0200;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        stall_in = 1'b0;
        exp_q.delete();
        expect_seq(32'h0000_0200, 40);
        @(negedge clk_in);
        check("flush_stall_valid", ifid_valid_out, 0);
        check("flush_stall_req", imem_req_out, 1);
        check("flush_stall_addr", imem_addr_out, 32'h0000_0200);
        @(negedge clk_in);
        check("flush_queue_empty", ifid_valid_out, 0);
        @(posedge clk_in);
        #1;
        cycles(6);

        // Reset in WAIT; the stale response lands while the FSM sits in REQ with gnt low.
        rv_lat = 4;
        wait_grant("reset_grant", addr);
        @(posedge clk_in);
        #1;
        imem_gnt_in = 1'b0;
        rst_n_in    = 1'b0;
        #1;
        check("mid_rst_req", imem_req_out, 0);
        check("mid_rst_addr", imem_addr_out, 32'h0);
        check("mid_rst_valid", ifid_valid_out, 0);
        check("mid_rst_pc", ifid_pc_out, 32'h0);
        check("mid_rst_instr", ifid_instr_out, RST_INSTR);
        exp_q.delete();
        cycles(1);
        rst_n_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!imem_rvalid_in && n < 10);
        check("stale_rvalid_seen", imem_rvalid_in, 1);
        check("stale_req", imem_req_out, 1);
        check("stale_addr", imem_addr_out, 32'h0);
        @(posedge clk_in);
        #1;
        expect_seq(32'h0, 30);
        rv_lat      = 1;
        imem_gnt_in = 1'b1;
        cycles(12);

        // PC wrap at the top of the address space.
        flush_in       = 1'b1;
        redirect_pc_in = 32'hFFFF_FFF8;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        exp_q.delete();
        expect_seq(32'hFFFF_FFF8, 20);
        wait_grant("wrap_f8", addr);
        check("wrap_f8", addr, 32'hFFFF_FFF8);
        wait_grant("wrap_fc", addr);
        check("wrap_fc", addr, 32'hFFFF_FFFC);
        wait_grant("wrap_0", addr);
        check("wrap_0", addr, 32'h0000_0000);
        @(posedge clk_in);
        #1;
        cycles(10);

        check("sb_min_matched", (matched >= 12) ? 32'd1 : 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline; feeds the IF/ID register consumed by decode and the hazard unit.
- Owns the PC, runs a req/gnt/rvalid handshake to instruction memory with one outstanding request, and buffers returned words in a small FIFO.
- Honours stall (load-use) and flush (branch redirect) from the hazard unit.

Parameters:
- WIDTH, 32, PC/instruction width.
- DEPTH, 2, fetch-queue entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- stall_in  input  1  hold IF/ID contents.
- flush_in  input  1  discard everything in flight and redirect fetch.
- redirect_pc_in  input  WIDTH  new fetch PC when flush_in=1.
- imem_req_out  output  1  fetch request.
- imem_addr_out  output  WIDTH  fetch address (word aligned).
- imem_gnt_in  input  1  request accepted this cycle.
- imem_rvalid_in  input  1  response data valid.
- imem_rdata_in  input  WIDTH  response instruction.
- ifid_valid_out  output  1  IF/ID slot holds a real instruction.
- ifid_pc_out  output  WIDTH  PC of IF/ID instruction.
- ifid_instr_out  output  WIDTH  IF/ID instruction.

Behaviour:
- Reset (rst_n_in=0, asynchronous):
  - pc=RESET_PC; FSM=IDLE; queue empty.
  - imem_req_out=0; ifid_valid_out=0; ifid_pc_out=0; ifid_instr_out=0.
- Address rules:
  - imem_addr_out=pc. Bits [1:0] of pc and of redirect_pc_in are forced to 0.
  - pc+4 wraps modulo 2^WIDTH.
- FSM:
  - IDLE: go to REQ when queue occupancy (after this cycle's pop) < DEPTH.
  - REQ: imem_req_out=1. On gnt: pc<=pc+4, record issued pc, go to WAIT.
  - WAIT: imem_req_out=0. On rvalid: push {issued pc, rdata}. Next state is REQ if space remains after push/pop, else IDLE.
  - DROP: imem_req_out=0. Wait for rvalid, discard the data, go to REQ.
- Space accounting: pop and push in the same cycle are both allowed. Never push into a full queue; the one-outstanding rule guarantees this.
- IF/ID register load (when stall_in=0 and flush_in=0):
  - Queue non-empty: load head, pop, ifid_valid_out<=1.
  - Queue empty: ifid_valid_out<=0; pc and instr hold their values.
- stall_in=1: IF/ID holds. Fetch continues until the queue is full, then the FSM parks in IDLE.
- Latency: gnt at cycle t, rvalid at t+k, ifid_valid_out=1 at t+k+1 at the earliest. No bypass around the queue.
- flush_in=1 overrides stall_in, in every state:
  - pc<=redirect_pc_in; queue cleared; ifid_valid_out<=0.
  - REQ, gnt=0: stay in REQ with the new address next cycle. Imem permits address change or withdrawal while gnt=0.
  - REQ, gnt=1: go to DROP.
  - WAIT, rvalid=0: go to DROP.
  - WAIT, rvalid=1: discard the data, go to REQ.
  - DROP, rvalid=0: stay in DROP (pc updated). DROP, rvalid=1: go to REQ.
  - IDLE: go to REQ.
- Redirected instruction: the first instruction at the redirect target appears in IF/ID no earlier than 3 cycles after flush, given 1-cycle gnt and 1-cycle rvalid.
- Reset mid-transaction: all state cleared. Any late rvalid arriving after reset release while in IDLE/REQ is ignored.

Optional Feature:
- Macro: IF_FETCH_NOP_EN.
- Defined: whenever ifid_valid_out=0 (reset, flush, empty pop), ifid_instr_out=32'h0000_0013 (addi x0,x0,0) and ifid_pc_out=0. Decode may then ignore valid.
- Undefined: on invalid slots ifid_instr_out/ifid_pc_out hold their last values, except at reset, where they are 0.

Test Plan:
- Reset release, imem gnt and rvalid 1 cycle each, rdata=pc^32'hA5A5_0000 -> addresses 0,4,8... issued; ifid_valid_out first high 3 cycles after first req; ifid_pc_out increments by 4.
- stall_in held 6 cycles from steady stream -> IF/ID frozen; exactly DEPTH=2 more responses accepted; imem_req_out=0 while the queue is full; on release PCs continue with no gap or duplicate.
- flush_in with redirect_pc_in=32'h0000_0103 while in WAIT -> next rvalid dropped; next request address 32'h0000_0100; the old-path instruction never reaches IF/ID.
- flush_in and stall_in together, with queue full -> ifid_valid_out=0 next cycle; queue empty; fetch resumes at the redirect.
- rst_n_in pulsed low mid-WAIT, then a stale rvalid -> all outputs return to reset values; the stale rvalid is ignored; fetch restarts at RESET_PC.
- pc=32'hFFFF_FFFC fetched -> next address 32'h0000_0000. With IF_FETCH_NOP_EN: during the empty queue ifid_instr_out=32'h0000_0013.
